// File: rtl/lsb_queue.sv
`default_nettype none
// ============================================================================
// Module : lsb_queue
// Program-ordered load/store queue: CDB snooping, address generation,
//          in-order memory issue from the head, flush-surviving stores.
// Rev    : 1.0
// ============================================================================
module lsb_queue #(
  parameter int DEPTH = 16,
  parameter int XLEN  = 32,
  parameter int ROB_W = 4,
  parameter int CDB_N = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     rdy_i,
  input  logic                     flush_i,
  input  logic                     disp_valid_i,
  output logic                     disp_ready_o,
  input  logic                     disp_is_store_i,
  input  logic [1:0]               disp_size_i,
  input  logic                     disp_unsigned_i,
  input  logic [ROB_W-1:0]         disp_rob_idx_i,
  input  logic                     disp_rs1_rdy_i,
  input  logic                     disp_rs2_rdy_i,
  input  logic [ROB_W-1:0]         disp_rs1_tag_i,
  input  logic [ROB_W-1:0]         disp_rs2_tag_i,
  input  logic [XLEN-1:0]          disp_rs1_val_i,
  input  logic [XLEN-1:0]          disp_rs2_val_i,
  input  logic [11:0]              disp_imm_i,
  input  logic [CDB_N-1:0]         cdb_valid_i,
  input  logic [CDB_N*ROB_W-1:0]   cdb_tag_i,
  input  logic [CDB_N*XLEN-1:0]    cdb_data_i,
  input  logic                     commit_store_valid_i,
  output logic                     addr_valid_o,
  output logic [ROB_W-1:0]         addr_rob_idx_o,
  output logic [XLEN-1:0]          addr_value_o,
  output logic                     st_ready_valid_o,
  output logic [ROB_W-1:0]         st_ready_rob_idx_o,
  output logic                     mem_req_valid_o,
  output logic                     mem_req_we_o,
  output logic [1:0]               mem_req_size_o,
  output logic [XLEN-1:0]          mem_req_addr_o,
  output logic [XLEN-1:0]          mem_req_wdata_o,
  input  logic                     mem_ack_i,
  input  logic [XLEN-1:0]          mem_rdata_i,
  output logic                     ld_wb_valid_o,
  output logic [ROB_W-1:0]         ld_wb_rob_idx_o,
  output logic [XLEN-1:0]          ld_wb_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_COMMIT, S_MEM, S_DROP} state_e;

  logic [DEPTH-1:0] valid_q, is_store_q, uns_q, rs1_rdy_q, rs2_rdy_q, addr_ok_q, committed_q;
  logic [1:0]       size_q    [DEPTH];
  logic [ROB_W-1:0] rob_q     [DEPTH];
  logic [ROB_W-1:0] rs1_tag_q [DEPTH];
  logic [ROB_W-1:0] rs2_tag_q [DEPTH];
  logic [XLEN-1:0]  rs1_val_q [DEPTH];
  logic [XLEN-1:0]  rs2_val_q [DEPTH];
  logic [XLEN-1:0]  addr_q    [DEPTH];
  logic [11:0]      imm_q     [DEPTH];

  logic [PW-1:0] head_q, tail_q, head_d, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q;
  state_e        state_q;

  logic             addr_valid_q, st_ready_valid_q, mem_req_valid_q, mem_req_we_q, ld_wb_valid_q;
  logic [ROB_W-1:0] addr_rob_q, st_ready_rob_q, ld_wb_rob_q;
  logic [XLEN-1:0]  addr_value_q, mem_req_addr_q, mem_req_wdata_q, ld_wb_data_q;
  logic [1:0]       mem_req_size_q;

  // Returns {hit, value}; scanning downward lets the lowest channel win.
  function automatic logic [XLEN:0] cdb_lookup(
    input logic [ROB_W-1:0]       tag,
    input logic [CDB_N-1:0]       v,
    input logic [CDB_N*ROB_W-1:0] t,
    input logic [CDB_N*XLEN-1:0]  d
  );
    logic [XLEN:0] r;
    r = '0;
    for (int c = CDB_N - 1; c >= 0; c--) begin
      if (v[c] && t[c*ROB_W +: ROB_W] == tag) r = {1'b1, d[c*XLEN +: XLEN]};
    end
    return r;
  endfunction

  logic [XLEN:0] w_snoop1 [DEPTH];
  logic [XLEN:0] w_snoop2 [DEPTH];
  logic [XLEN:0] w_disp1, w_disp2;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_snoop
    assign w_snoop1[gi] = cdb_lookup(rs1_tag_q[gi], cdb_valid_i, cdb_tag_i, cdb_data_i);
    assign w_snoop2[gi] = cdb_lookup(rs2_tag_q[gi], cdb_valid_i, cdb_tag_i, cdb_data_i);
  end
  assign w_disp1 = cdb_lookup(disp_rs1_tag_i, cdb_valid_i, cdb_tag_i, cdb_data_i);
  assign w_disp2 = cdb_lookup(disp_rs2_tag_i, cdb_valid_i, cdb_tag_i, cdb_data_i);

  logic             w_au_found, w_cm_found;
  logic [PW-1:0]    w_au_idx, w_cm_idx, w_idx;
  logic [DEPTH-1:0] w_keep;
  logic [CW-1:0]    w_keep_cnt;
  logic [XLEN-1:0]  w_au_addr;

  always_comb begin
    w_au_found = 1'b0;
    w_au_idx   = '0;
    w_cm_found = 1'b0;
    w_cm_idx   = '0;
    w_idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = head_q + PW'(k);
      if (!w_au_found && valid_q[w_idx] && rs1_rdy_q[w_idx] && !addr_ok_q[w_idx]) begin
        w_au_found = 1'b1;
        w_au_idx   = w_idx;
      end
      if (!w_cm_found && valid_q[w_idx] && is_store_q[w_idx] && !committed_q[w_idx]) begin
        w_cm_found = 1'b1;
        w_cm_idx   = w_idx;
      end
    end
    // Entries surviving a flush: committed stores, including one committed this cycle.
    w_keep     = '0;
    w_keep_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_keep[i]  = valid_q[i] && (committed_q[i] ||
                   (commit_store_valid_i && w_cm_found && w_cm_idx == PW'(i)));
      w_keep_cnt = w_keep_cnt + CW'(w_keep[i]);
    end
    w_au_addr = rs1_val_q[w_au_idx] + {{(XLEN-12){imm_q[w_au_idx][11]}}, imm_q[w_au_idx]};
  end

  logic w_accept, w_deq, w_head_ok, w_issue, w_st_ready;
  assign w_accept  = disp_valid_i && !full_q && !flush_i;
  assign w_deq     = (state_q == S_MEM) && mem_ack_i;
  assign w_head_ok = !flush_i && valid_q[head_q] && addr_ok_q[head_q] &&
                     (!is_store_q[head_q] || rs2_rdy_q[head_q]);

  always_comb begin
    w_issue    = 1'b0;
    w_st_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        w_issue    = w_head_ok && (!is_store_q[head_q] || committed_q[head_q]);
        w_st_ready = w_head_ok && is_store_q[head_q] && !committed_q[head_q];
      end
      S_WAIT_COMMIT: w_issue = committed_q[head_q];
      default: ;
    endcase
  end

  always_comb begin
    if (flush_i) begin
      head_d  = head_q + PW'(w_deq && w_keep[head_q]);
      tail_d  = head_q + w_keep_cnt[PW-1:0];
      count_d = w_keep_cnt - CW'(w_deq && w_keep[head_q]);
    end else begin
      head_d  = head_q + PW'(w_deq);
      tail_d  = tail_q + PW'(w_accept);
      count_d = count_q + CW'(w_accept) - CW'(w_deq);
    end
  end

  logic [XLEN-1:0] w_ld_data;
  always_comb begin
    case (size_q[head_q])
      2'd0:    w_ld_data = {{(XLEN-8){~uns_q[head_q] & mem_rdata_i[7]}}, mem_rdata_i[7:0]};
      2'd1:    w_ld_data = {{(XLEN-16){~uns_q[head_q] & mem_rdata_i[15]}}, mem_rdata_i[15:0]};
      default: w_ld_data = mem_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        size_q[i]    <= '0;
        rob_q[i]     <= '0;
        rs1_tag_q[i] <= '0;
        rs2_tag_q[i] <= '0;
        rs1_val_q[i] <= '0;
        rs2_val_q[i] <= '0;
        addr_q[i]    <= '0;
        imm_q[i]     <= '0;
      end
      valid_q          <= '0;
      is_store_q       <= '0;
      uns_q            <= '0;
      rs1_rdy_q        <= '0;
      rs2_rdy_q        <= '0;
      addr_ok_q        <= '0;
      committed_q      <= '0;
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      full_q           <= 1'b0;
      state_q          <= S_IDLE;
      addr_valid_q     <= 1'b0;
      addr_rob_q       <= '0;
      addr_value_q     <= '0;
      st_ready_valid_q <= 1'b0;
      st_ready_rob_q   <= '0;
      mem_req_valid_q  <= 1'b0;
      mem_req_we_q     <= 1'b0;
      mem_req_size_q   <= '0;
      mem_req_addr_q   <= '0;
      mem_req_wdata_q  <= '0;
      ld_wb_valid_q    <= 1'b0;
      ld_wb_rob_q      <= '0;
      ld_wb_data_q     <= '0;
    end else if (rdy_i) begin
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      full_q           <= (count_d == CW'(DEPTH));
      addr_valid_q     <= 1'b0;
      st_ready_valid_q <= 1'b0;
      ld_wb_valid_q    <= 1'b0;

      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && !rs1_rdy_q[i] && w_snoop1[i][XLEN]) begin
          rs1_rdy_q[i] <= 1'b1;
          rs1_val_q[i] <= w_snoop1[i][XLEN-1:0];
        end
        if (valid_q[i] && !rs2_rdy_q[i] && w_snoop2[i][XLEN]) begin
          rs2_rdy_q[i] <= 1'b1;
          rs2_val_q[i] <= w_snoop2[i][XLEN-1:0];
        end
        if (flush_i && !w_keep[i]) valid_q[i] <= 1'b0;
      end

      if (commit_store_valid_i && w_cm_found) committed_q[w_cm_idx] <= 1'b1;

      if (w_au_found && !flush_i) begin
        addr_q[w_au_idx]    <= w_au_addr;
        addr_ok_q[w_au_idx] <= 1'b1;
        addr_valid_q        <= 1'b1;
        addr_rob_q          <= rob_q[w_au_idx];
        addr_value_q        <= w_au_addr;
      end

      if (w_deq) valid_q[head_q] <= 1'b0;

      if (w_accept) begin
        valid_q[tail_q]     <= 1'b1;
        is_store_q[tail_q]  <= disp_is_store_i;
        size_q[tail_q]      <= disp_size_i;
        uns_q[tail_q]       <= disp_unsigned_i;
        rob_q[tail_q]       <= disp_rob_idx_i;
        rs1_tag_q[tail_q]   <= disp_rs1_tag_i;
        rs2_tag_q[tail_q]   <= disp_rs2_tag_i;
        rs1_rdy_q[tail_q]   <= disp_rs1_rdy_i || w_disp1[XLEN];
        rs2_rdy_q[tail_q]   <= disp_rs2_rdy_i || w_disp2[XLEN];
        rs1_val_q[tail_q]   <= disp_rs1_rdy_i ? disp_rs1_val_i : w_disp1[XLEN-1:0];
        rs2_val_q[tail_q]   <= disp_rs2_rdy_i ? disp_rs2_val_i : w_disp2[XLEN-1:0];
        imm_q[tail_q]       <= disp_imm_i;
        addr_ok_q[tail_q]   <= 1'b0;
        committed_q[tail_q] <= 1'b0;
      end

      if (w_issue) begin
        state_q         <= S_MEM;
        mem_req_valid_q <= 1'b1;
        mem_req_we_q    <= is_store_q[head_q];
        mem_req_size_q  <= size_q[head_q];
        mem_req_addr_q  <= addr_q[head_q];
        mem_req_wdata_q <= rs2_val_q[head_q];
      end else begin
        case (state_q)
          S_IDLE: begin
            if (w_st_ready) begin
              st_ready_valid_q <= 1'b1;
              st_ready_rob_q   <= rob_q[head_q];
              state_q          <= S_WAIT_COMMIT;
            end
          end
          S_WAIT_COMMIT: begin
            if (flush_i && !w_keep[head_q]) state_q <= S_IDLE;
          end
          S_MEM: begin
            if (mem_ack_i) begin
              mem_req_valid_q <= 1'b0;
              state_q         <= S_IDLE;
              if (!mem_req_we_q && !flush_i) begin
                ld_wb_valid_q <= 1'b1;
                ld_wb_rob_q   <= rob_q[head_q];
                ld_wb_data_q  <= w_ld_data;
              end
            end else if (flush_i && !mem_req_we_q) begin
              state_q <= S_DROP;
            end
          end
          S_DROP: begin
            if (mem_ack_i) begin
              mem_req_valid_q <= 1'b0;
              state_q         <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign disp_ready_o       = ~full_q;
  assign full_o             = full_q;
  assign count_o            = count_q;
  assign addr_valid_o       = addr_valid_q;
  assign addr_rob_idx_o     = addr_rob_q;
  assign addr_value_o       = addr_value_q;
  assign st_ready_valid_o   = st_ready_valid_q;
  assign st_ready_rob_idx_o = st_ready_rob_q;
  assign mem_req_valid_o    = mem_req_valid_q;
  assign mem_req_we_o       = mem_req_we_q;
  assign mem_req_size_o     = mem_req_size_q;
  assign mem_req_addr_o     = mem_req_addr_q;
  assign mem_req_wdata_o    = mem_req_wdata_q;
  assign ld_wb_valid_o      = ld_wb_valid_q;
  assign ld_wb_rob_idx_o    = ld_wb_rob_q;
  assign ld_wb_data_o       = ld_wb_data_q;

endmodule
`default_nettype wire
